cache_refill_ctrl: RTL and testbench

//  Control stage directly upstream of the 16-word direct-mapped cache (4 lines x 4 words, 1-bit tag).

---
 rtl/cache_refill_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Read-request controller in front of a 4-line x 4-word
//            direct-mapped cache with a 1-bit tag. A lookup that hits returns
//            the cached word. A lookup that misses fetches the whole line from
//            memory one word at a time, loads it into the cache over the
//            one-hot line-load bus, looks up again and returns the word.
//            First-lookup hits and misses are counted in saturating counters.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        clock; synchronous active-low reset
//   cpu_req/addr    read request, held with its address until cpu_ready
//   cpu_ready/rdata one-cycle completion pulse with registered read data
//   cache_tag/index/offset  lookup controls, taken from the latched address
//   cache_load_bus  one-hot line load (bit LINES-1-i loads line i)
//   cache_line_bus  fill data, line i word w in slot 4i+w counted from MSB
//   cache_hit/data  combinational lookup result from the cache
//   mem_req/addr    word read request to memory, held until mem_ack
//   mem_ack/rdata   memory word return
//   hit_cnt/miss_cnt saturating first-lookup statistics
// ============================================================================
module cache_refill_ctrl #(
  parameter  int WIDTH      = 32,
  parameter  int CACHE_SIZE = 16,
  parameter  int CNT_W      = 16,
  localparam int c_WORDS    = 4,
  localparam int c_LINES    = CACHE_SIZE / c_WORDS,
  localparam int c_OFF_W    = $clog2(c_WORDS),
  localparam int c_IDX_W    = $clog2(c_LINES),
  localparam int c_ADDR_W   = 1 + $clog2(CACHE_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req,
  input  logic [c_ADDR_W-1:0]           cpu_addr,
  output logic                          cpu_ready,
  output logic [WIDTH-1:0]              cpu_rdata,
  output logic                          cache_tag,
  output logic [c_IDX_W-1:0]            cache_index,
  output logic [c_ADDR_W-2:0]           cache_offset,
  output logic [c_LINES-1:0]            cache_load_bus,
  output logic [WIDTH*CACHE_SIZE-1:0]   cache_line_bus,
  input  logic                          cache_hit,
  input  logic [WIDTH-1:0]              cache_data,
  output logic                          mem_req,
  output logic [c_ADDR_W-1:0]           mem_addr,
  input  logic                          mem_ack,
  input  logic [WIDTH-1:0]              mem_rdata,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic [CNT_W-1:0]              miss_cnt
);

  localparam logic [CNT_W-1:0]   c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [c_OFF_W-1:0] c_OFF_ONE   = {{(c_OFF_W-1){1'b0}}, 1'b1};
  localparam logic [c_OFF_W-1:0] c_LAST_WORD = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_LOAD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                         r_state;
  logic [c_ADDR_W-1:0]            r_addr;
  logic                           r_second;   // set for the lookup that follows a fill
  logic [c_OFF_W-1:0]             r_cnt;
  logic [c_WORDS-1:0][WIDTH-1:0]  r_buf;
  logic                           r_mem_req;
  logic                           r_ready;
  logic [WIDTH-1:0]               r_rdata;
  logic [c_LINES-1:0]             r_load_bus;
  logic [CNT_W-1:0]               r_hit_cnt;
  logic [CNT_W-1:0]               r_miss_cnt;

  logic [c_IDX_W-1:0]             w_index;
  logic [c_LINES-1:0]             w_load_onehot;

  assign w_index      = r_addr[c_ADDR_W-2:c_OFF_W];
  assign cache_tag    = r_addr[c_ADDR_W-1];
  assign cache_index  = w_index;
  assign cache_offset = r_addr[c_ADDR_W-2:0];
  assign mem_addr     = {r_addr[c_ADDR_W-1:c_OFF_W], r_cnt};

  assign cpu_ready      = r_ready;
  assign cpu_rdata      = r_rdata;
  assign mem_req        = r_mem_req;
  assign cache_load_bus = r_load_bus;
  assign hit_cnt        = r_hit_cnt;
  assign miss_cnt       = r_miss_cnt;

  // Line i is loaded by bit LINES-1-i, so the MSB selects line 0.
  always_comb begin
    w_load_onehot = '0;
    for (int i = 0; i < c_LINES; i++) begin
      if (w_index == i[c_IDX_W-1:0]) begin
        w_load_onehot[c_LINES-1-i] = 1'b1;
      end
    end
  end

  // The fill buffer appears only in the slot of the line being loaded; the
  // load bus is non-zero only during LOAD, so every slot is zero otherwise.
  for (genvar l = 0; l < c_LINES; l++) begin : g_line
    for (genvar w = 0; w < c_WORDS; w++) begin : g_word
      assign cache_line_bus[WIDTH*(CACHE_SIZE-(l*c_WORDS+w))-1 -: WIDTH] =
        r_load_bus[c_LINES-1-l] ? r_buf[w] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_second   <= 1'b0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_mem_req  <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_load_bus <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr   <= cpu_addr;
            r_second <= 1'b0;
            r_state  <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (cache_hit) begin
            r_rdata <= cache_data;
            r_ready <= 1'b1;
            if (!r_second && !(&r_hit_cnt)) begin
              r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
            end
            r_state <= S_RESP;
          end else begin
            // A miss on the post-fill lookup simply refills again.
            if (!r_second && !(&r_miss_cnt)) begin
              r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
            end
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_state   <= S_FILL;
          end
        end

        S_FILL: begin
          if (r_mem_req) begin
            if (mem_ack) begin
              r_buf[r_cnt] <= mem_rdata;
              r_cnt        <= r_cnt + c_OFF_ONE;
              r_mem_req    <= 1'b0;       // one idle cycle after every ack
              if (r_cnt == c_LAST_WORD) begin
                r_load_bus <= w_load_onehot;
                r_state    <= S_LOAD;
              end
            end
          end else begin
            r_mem_req <= 1'b1;
          end
        end

        S_LOAD: begin
          r_load_bus <= '0;
          r_second   <= 1'b1;
          r_state    <= S_LOOKUP;
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Self-checking bench for cache_refill_ctrl. Surrounds the
//            controller with a behavioural cache (filled only through the
//            load bus) and a memory with random ack delays, and predicts
//            hits, fills, latencies and counters from a line-tag model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_refill_ctrl;

  localparam int WIDTH      = 32;
  localparam int CACHE_SIZE = 16;
  localparam int CNT_W      = 4;
  localparam int MAXC       = (1 << CNT_W) - 1;
  localparam int LBW        = WIDTH * CACHE_SIZE;

  logic                clk;
  logic                rst;
  logic                cpu_req;
  logic [4:0]          cpu_addr;
  logic                cpu_ready;
  logic [WIDTH-1:0]    cpu_rdata;
  logic                cache_tag;
  logic [1:0]          cache_index;
  logic [3:0]          cache_offset;
  logic [3:0]          cache_load_bus;
  logic [LBW-1:0]      cache_line_bus;
  logic                cache_hit;
  logic [WIDTH-1:0]    cache_data;
  logic                mem_req;
  logic [4:0]          mem_addr;
  logic                mem_ack;
  logic [WIDTH-1:0]    mem_rdata;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    miss_cnt;

  cache_refill_ctrl #(
    .WIDTH      (WIDTH),
    .CACHE_SIZE (CACHE_SIZE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ready      (cpu_ready),
    .cpu_rdata      (cpu_rdata),
    .cache_tag      (cache_tag),
    .cache_index    (cache_index),
    .cache_offset   (cache_offset),
    .cache_load_bus (cache_load_bus),
    .cache_line_bus (cache_line_bus),
    .cache_hit      (cache_hit),
    .cache_data     (cache_data),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Environment: memory contents and the cache the controller drives.
  logic [WIDTH-1:0] mem [32];
  logic             env_valid [4];
  logic             env_tag [4];
  logic [WIDTH-1:0] env_data [16];

  // Reference model: which tag each line holds, and the statistics.
  bit               ref_valid [4];
  bit               ref_tag [4];
  int               ref_hits;
  int               ref_misses;

  logic [4:0]       mem_log [$];
  logic [LBW+3:0]   load_log [$];
  int               req_cycles;

  always_comb begin
    cache_hit  = env_valid[cache_index] && (env_tag[cache_index] == cache_tag);
    cache_data = env_data[cache_offset];
  end

  task automatic chk(input string name, input logic [LBW-1:0] act, input logic [LBW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slot_word(input logic [LBW-1:0] bus, input int s);
    return bus[WIDTH*(CACHE_SIZE-s)-1 -: WIDTH];
  endfunction

  function automatic logic [LBW-1:0] exp_line(input logic [4:0] a);
    logic [LBW-1:0] v;
    int             idx;
    v   = '0;
    idx = int'(a[3:2]);
    for (int w = 0; w < 4; w++) begin
      v[WIDTH*(CACHE_SIZE-(4*idx+w))-1 -: WIDTH] = mem[{a[4:2], w[1:0]}];
    end
    return v;
  endfunction

  // Memory responder and load-bus observer, acting 1 time unit after each edge.
  initial begin : p_env
    bit         prev_req;
    bit         acked;
    int         wait_n;
    logic [4:0] held;
    prev_req  = 1'b0;
    acked     = 1'b0;
    wait_n    = 0;
    held      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      env_valid[i] = 1'b0;
      env_tag[i]   = 1'b0;
    end
    for (int i = 0; i < 16; i++) env_data[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acked) chk("mem_req_gap_after_ack", mem_req, 0);
      acked     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (cache_load_bus != 4'b0000) begin
        load_log.push_back({cache_load_bus, cache_line_bus});
        for (int l = 0; l < 4; l++) begin
          if (cache_load_bus[3-l]) begin
            env_valid[l] = 1'b1;
            env_tag[l]   = cache_tag;
            for (int w = 0; w < 4; w++) env_data[4*l+w] = slot_word(cache_line_bus, 4*l+w);
          end
        end
      end
      if (mem_req && rst) begin
        req_cycles++;
        if (!prev_req) begin
          // never ack in the cycle the request rises
          wait_n = $urandom_range(0, 3);
          held   = mem_addr;
        end else begin
          chk("mem_addr_stable", mem_addr, held);
          if (wait_n == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            mem_log.push_back(mem_addr);
            acked     = 1'b1;
          end else begin
            wait_n--;
          end
        end
      end
      prev_req = mem_req && rst;
    end
  end

  // One complete CPU read, checked against the reference model.
  task automatic do_read(input logic [4:0] a, input bit perturb,
                         output bit was_hit, output logic [3:0] load_seen);
    int         cyc;
    int         ph;
    bit         exp_hit;
    logic [1:0] idx;
    idx     = a[3:2];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == a[4]);
    @(negedge clk);
    mem_log.delete();
    load_log.delete();
    req_cycles = 0;
    cpu_req    = 1'b1;
    cpu_addr   = a;
    cyc        = 0;
    ph         = 0;
    while (!cpu_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (perturb) begin
        if (ph == 0 && mem_req) begin
          cpu_req = 1'b0; cpu_addr = ~a; ph = 1;
        end else if (ph == 1) begin
          cpu_req = 1'b1; ph = 2;
        end else if (ph == 2) begin
          cpu_addr = a; ph = 3;
        end
      end
    end
    chk("ready_seen", cpu_ready, 1);
    was_hit   = (mem_log.size() == 0);
    load_seen = (load_log.size() > 0) ? load_log[0][LBW+3:LBW] : 4'b0000;
    chk("hit_vs_model", was_hit, exp_hit);
    chk("rdata", cpu_rdata, mem[a]);
    if (exp_hit) begin
      chk("hit_latency", cyc, 2);
      chk("hit_no_load", load_log.size(), 0);
      if (ref_hits < MAXC) ref_hits++;
    end else begin
      chk("miss_latency", cyc, req_cycles + 7);
      chk("ack_count", mem_log.size(), 4);
      for (int w = 0; w < 4; w++) begin
        if (w < mem_log.size()) chk("fill_addr", mem_log[w], {a[4:2], w[1:0]});
      end
      chk("load_count", load_log.size(), 1);
      if (load_log.size() > 0) begin
        chk("load_bus", load_log[0][LBW+3:LBW], 4'b1000 >> idx);
        chk("line_bus", load_log[0][LBW-1:0], exp_line(a));
      end
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[4];
      if (ref_misses < MAXC) ref_misses++;
    end
    chk("hit_cnt", hit_cnt, ref_hits);
    chk("miss_cnt", miss_cnt, ref_misses);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ready_pulse_width", cpu_ready, 0);
  endtask

  typedef struct {
    logic [4:0] addr;
    bit         exp_hit;
    logic [3:0] exp_load;
    int         exp_hits;
    int         exp_misses;
  } vec_t;

  vec_t tbl [9];

  initial begin : p_main
    bit         h;
    logic [3:0] lb;
    int         cyc;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = {16'($urandom_range(0, 65535)), 16'(32'hA0 + i)};
    for (int i = 0; i < 4; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 1'b0;
    end
    ref_hits   = 0;
    ref_misses = 0;

    tbl[0] = '{5'h05, 1'b0, 4'b0100, 0, 1};
    tbl[1] = '{5'h05, 1'b1, 4'b0000, 1, 1};
    tbl[2] = '{5'h15, 1'b0, 4'b0100, 1, 2};
    tbl[3] = '{5'h05, 1'b0, 4'b0100, 1, 3};
    tbl[4] = '{5'h06, 1'b1, 4'b0000, 2, 3};
    tbl[5] = '{5'h00, 1'b0, 4'b1000, 2, 4};
    tbl[6] = '{5'h1F, 1'b0, 4'b0001, 2, 5};
    tbl[7] = '{5'h1C, 1'b1, 4'b0000, 3, 5};
    tbl[8] = '{5'h0B, 1'b0, 4'b0010, 3, 6};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_load_bus", cache_load_bus, 0);
    chk("rst_line_bus", cache_line_bus, 0);
    chk("rst_offset", cache_offset, 0);
    chk("rst_tag", cache_tag, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_read(tbl[i].addr, 1'b0, h, lb);
      chk("tbl_hit", h, tbl[i].exp_hit);
      chk("tbl_load", lb, tbl[i].exp_load);
      chk("tbl_hit_cnt", hit_cnt, tbl[i].exp_hits);
      chk("tbl_miss_cnt", miss_cnt, tbl[i].exp_misses);
    end

    // Reset after the second ack of a fill aborts it
    @(negedge clk);
    mem_log.delete();
    load_log.delete();
    cpu_req  = 1'b1;
    cpu_addr = 5'h14;
    cyc      = 0;
    while (mem_log.size() < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_two_acks", mem_log.size(), 2);
    @(negedge clk);
    rst     = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_load_bus", cache_load_bus, 0);
    chk("abort_ready", cpu_ready, 0);
    chk("abort_hit_cnt", hit_cnt, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    chk("abort_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_load", load_log.size(), 0);
    chk("abort_idle_mem_req", mem_req, 0);
    ref_hits   = 0;
    ref_misses = 0;

    // Hit counter saturation, then a miss with cpu_req/addr disturbed mid-fill
    for (int i = 0; i < 18; i++) do_read(5'h1C, 1'b0, h, lb);
    chk("hit_cnt_saturated", hit_cnt, MAXC);
    do_read(5'h10, 1'b1, h, lb);

    // Random traffic
    for (int i = 0; i < 70; i++) begin
      do_read(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), h, lb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
